// File: rtl/unpool_serializer_pkg.sv
// Shared definitions for the argmax pooling pair: state encoding and default
// geometry used by both the comparator side and the unpool serializer.
package unpool_serializer_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int DEFAULT_N          = 4;
   localparam int DEFAULT_DATA_WIDTH = 13;

endpackage

// File: rtl/unpool_serializer.sv
// Unpool serializer: expands one (data, index) argmax token into N serial beats,
// placing the data at the winning position and FILL everywhere else.
module unpool_serializer
   import unpool_serializer_pkg::*;
#(
   parameter int                    N           = DEFAULT_N,
   parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] FILL        = {DATA_WIDTH{1'b0}},
   localparam int                   INDEX_WIDTH = $clog2(N)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [INDEX_WIDTH-1:0] in_index,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_hit,
   output logic                   out_last,
   output logic                   err
);

   // One extra counter bit so N itself is representable when N is a power of two.
   localparam int               CNT_W    = INDEX_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_CNT  = {{INDEX_WIDTH{1'b0}}, 1'b1};

   state_t                 state_r;
   state_t                 state_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [CNT_W-1:0]       cnt_s;
   logic [DATA_WIDTH-1:0]  data_r;
   logic [DATA_WIDTH-1:0]  data_s;
   logic [INDEX_WIDTH-1:0] idx_r;
   logic [INDEX_WIDTH-1:0] idx_s;
   logic                   err_r;
   logic                   out_valid_r;
   logic                   out_hit_r;
   logic                   out_last_r;
   logic [DATA_WIDTH-1:0]  out_data_r;

   logic                   in_ready_s;
   logic                   accept_s;
   logic                   beat_done_s;
   logic                   last_beat_s;
   logic                   bad_index_s;
   logic                   hit_s;

   assign last_beat_s = (cnt_r == LAST_CNT);
   assign beat_done_s = out_valid_r && out_ready;
   assign in_ready_s  = (state_r == IDLE) || ((state_r == EMIT) && out_ready && last_beat_s);
   assign accept_s    = in_valid && in_ready_s;
   assign bad_index_s = ({1'b0, in_index} >= N_CNT);
   // Out-of-range indices never match since cnt stops at N-1, so those tokens emit all FILL.
   assign hit_s       = (state_s == EMIT) && ({1'b0, idx_s} == cnt_s);

   // Next-state, beat counter and token capture.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      data_s  = data_r;
      idx_s   = idx_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = EMIT;
               cnt_s   = ZERO_CNT;
               data_s  = in_data;
               idx_s   = in_index;
            end else begin
               state_s = IDLE;
            end
         end
         EMIT: begin
            if (beat_done_s) begin
               if (last_beat_s) begin
                  if (accept_s) begin
                     state_s = EMIT;
                     cnt_s   = ZERO_CNT;
                     data_s  = in_data;
                     idx_s   = in_index;
                  end else begin
                     state_s = IDLE;
                     cnt_s   = ZERO_CNT;
                  end
               end else begin
                  cnt_s = cnt_r + ONE_CNT;
               end
            end else begin
               state_s = EMIT;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = ZERO_CNT;
         end
      endcase
   end

   // State registers plus outputs registered from the next-state view.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= ZERO_CNT;
         data_r      <= {DATA_WIDTH{1'b0}};
         idx_r       <= {INDEX_WIDTH{1'b0}};
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
         out_hit_r   <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= FILL;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         data_r      <= data_s;
         idx_r       <= idx_s;
         out_valid_r <= (state_s == EMIT);
         out_hit_r   <= hit_s;
         out_last_r  <= (state_s == EMIT) && (cnt_s == LAST_CNT);
         out_data_r  <= hit_s ? data_s : FILL;
         if (accept_s && bad_index_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_hit   = out_hit_r;
   assign out_last  = out_last_r;
   assign err       = err_r;

endmodule

// File: tb/tb_unpool_serializer.sv
// Bench for unpool_serializer: two instances (N=4/FILL=0 and N=3/FILL=1FFF)
// checked every cycle against a queue-of-beats model, plus literal scenarios.
module tb_unpool_serializer;

   localparam int DW = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         in_valid_v;
   logic [1:0]         in_ready_v;
   logic [1:0][DW-1:0] in_data_v;
   logic [1:0][1:0]    in_index_v;
   logic [1:0]         out_valid_v;
   logic [1:0]         out_ready_v;
   logic [1:0][DW-1:0] out_data_v;
   logic [1:0]         out_hit_v;
   logic [1:0]         out_last_v;
   logic [1:0]         err_v;

   unpool_serializer #(.N(4), .DATA_WIDTH(DW), .FILL(13'h0000)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .in_data(in_data_v[0]), .in_index(in_index_v[0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .out_data(out_data_v[0]), .out_hit(out_hit_v[0]),
      .out_last(out_last_v[0]), .err(err_v[0])
   );

   unpool_serializer #(.N(3), .DATA_WIDTH(DW), .FILL(13'h1FFF)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .in_data(in_data_v[1]), .in_index(in_index_v[1]),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .out_data(out_data_v[1]), .out_hit(out_hit_v[1]),
      .out_last(out_last_v[1]), .err(err_v[1])
   );

   int          nn [2];
   logic [DW-1:0] fillv [2];

   // Model: pending beats per instance, front = beat currently presented.
   logic [DW-1:0] q_data [2][$];
   bit            q_hit  [2][$];
   bit            q_last [2][$];
   bit            err_m  [2];
   bit            acc_m  [2];

   logic [DW-1:0] log_data [2][$];
   bit            log_hit  [2][$];
   bit            log_last [2][$];
   bit            log_rdy  [2][$];
   int            log_cyc  [2][$];
   int            cyc = 0;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] e36_d [4] = '{13'h0000, 13'h0000, 13'h00A5, 13'h0000};
   bit            e36_h [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   bit            e36_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   bit            e36_r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [DW-1:0] e37_d [8] = '{13'h1FFB, 13'h0000, 13'h0000, 13'h0000,
                                13'h0000, 13'h0000, 13'h0000, 13'h0007};
   logic [DW-1:0] e38_d [7] = '{13'h0000, 13'h0009, 13'h0009, 13'h0009,
                                13'h0009, 13'h0000, 13'h0000};
   bit            e38_h [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   bit            e38_r [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) begin
         log_data[d].delete(); log_hit[d].delete(); log_last[d].delete();
         log_rdy[d].delete();  log_cyc[d].delete();
      end
   endtask

   // Called at a falling edge with inputs already driven; checks, advances the model, moves one cycle.
   task automatic step();
      bit exp_rdy;
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_rdy = (q_data[d].size() == 0) || ((q_data[d].size() == 1) && out_ready_v[d]);
         chk($sformatf("d%0d in_ready", d), in_ready_v[d], exp_rdy);
         chk($sformatf("d%0d out_valid", d), out_valid_v[d], q_data[d].size() != 0);
         chk($sformatf("d%0d err", d), err_v[d], err_m[d]);
         if (q_data[d].size() != 0) begin
            chk($sformatf("d%0d out_data", d), out_data_v[d], q_data[d][0]);
            chk($sformatf("d%0d out_hit", d), out_hit_v[d], q_hit[d][0]);
            chk($sformatf("d%0d out_last", d), out_last_v[d], q_last[d][0]);
            log_data[d].push_back(out_data_v[d]);
            log_hit[d].push_back(out_hit_v[d]);
            log_last[d].push_back(out_last_v[d]);
            log_rdy[d].push_back(in_ready_v[d]);
            log_cyc[d].push_back(cyc);
         end
         acc_m[d] = in_valid_v[d] && exp_rdy;
         if ((q_data[d].size() != 0) && out_ready_v[d]) begin
            void'(q_data[d].pop_front());
            void'(q_hit[d].pop_front());
            void'(q_last[d].pop_front());
         end
         if (acc_m[d]) begin
            if (int'(in_index_v[d]) >= nn[d]) err_m[d] = 1'b1;
            for (int p = 0; p < nn[d]; p++) begin
               q_data[d].push_back((p == int'(in_index_v[d])) ? in_data_v[d] : fillv[d]);
               q_hit[d].push_back(p == int'(in_index_v[d]));
               q_last[d].push_back(p == nn[d] - 1);
            end
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid_v  = 2'b00;
      out_ready_v = 2'b11;
      for (int i = 0; i < 60; i++) begin
         if ((q_data[0].size() == 0) && (q_data[1].size() == 0)) break;
         step();
      end
      chk("drain d0", q_data[0].size(), 0);
      chk("drain d1", q_data[1].size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d out_valid", tag, d), out_valid_v[d], 1'b0);
         chk($sformatf("%s d%0d out_hit", tag, d), out_hit_v[d], 1'b0);
         chk($sformatf("%s d%0d out_last", tag, d), out_last_v[d], 1'b0);
         chk($sformatf("%s d%0d out_data", tag, d), out_data_v[d], fillv[d]);
         chk($sformatf("%s d%0d err", tag, d), err_v[d], 1'b0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      nn    = '{4, 3};
      fillv = '{13'h0000, 13'h1FFF};
      err_m = '{1'b0, 1'b0};
      in_valid_v  = 2'b00;
      out_ready_v = 2'b00;
      in_data_v   = '0;
      in_index_v  = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      chk("reset d0 in_ready", in_ready_v[0], 1'b1);
      chk("reset d1 in_ready", in_ready_v[1], 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single token: data 0A5 at index 2
      clear_logs();
      out_ready_v   = 2'b11;
      in_valid_v[0] = 1'b1; in_data_v[0] = 13'h00A5; in_index_v[0] = 2'd2;
      step();
      in_valid_v[0] = 1'b0;
      drain();
      chk("single beats", log_data[0].size(), 4);
      if (log_data[0].size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("single data[%0d]", i), log_data[0][i], e36_d[i]);
            chk($sformatf("single hit[%0d]", i), log_hit[0][i], e36_h[i]);
            chk($sformatf("single last[%0d]", i), log_last[0][i], e36_l[i]);
            chk($sformatf("single in_ready[%0d]", i), log_rdy[0][i], e36_r[i]);
         end
      end

      // Back-to-back: (-5, 0) then (7, 3) held valid until accepted
      clear_logs();
      in_valid_v[0] = 1'b1; in_data_v[0] = -13'sd5; in_index_v[0] = 2'd0;
      step();
      in_data_v[0] = 13'h0007; in_index_v[0] = 2'd3;
      for (int i = 0; i < 10; i++) begin
         step();
         if (acc_m[0]) break;
      end
      in_valid_v[0] = 1'b0;
      drain();
      chk("b2b beats", log_data[0].size(), 8);
      if (log_data[0].size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b data[%0d]", i), log_data[0][i], e37_d[i]);
         end
         chk("b2b span", log_cyc[0][7] - log_cyc[0][0], 7);
      end

      // Backpressure: stall three cycles on beat 1 of (9, 1)
      clear_logs();
      in_valid_v[0] = 1'b1; in_data_v[0] = 13'h0009; in_index_v[0] = 2'd1;
      step();
      in_valid_v[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         out_ready_v[0] = e38_r[i];
         step();
      end
      drain();
      chk("bp cycles", log_data[0].size(), 7);
      if (log_data[0].size() == 7) begin
         for (int i = 0; i < 7; i++) begin
            chk($sformatf("bp data[%0d]", i), log_data[0][i], e38_d[i]);
            chk($sformatf("bp hit[%0d]", i), log_hit[0][i], e38_h[i]);
         end
      end

      // Bad index on N=3 instance
      clear_logs();
      in_valid_v[1] = 1'b1; in_data_v[1] = 13'h0123; in_index_v[1] = 2'd3;
      step();
      in_valid_v[1] = 1'b0;
      drain();
      chk("bad beats", log_data[1].size(), 3);
      if (log_data[1].size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("bad data[%0d]", i), log_data[1][i], 13'h1FFF);
            chk($sformatf("bad hit[%0d]", i), log_hit[1][i], 1'b0);
         end
      end
      repeat (3) step();
      chk("bad err sticky", err_v[1], 1'b1);

      // Reset during beat 1
      in_valid_v[0] = 1'b1; in_data_v[0] = 13'h0055; in_index_v[0] = 2'd1;
      step();
      in_valid_v[0] = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      for (int d = 0; d < 2; d++) begin
         q_data[d].delete(); q_hit[d].delete(); q_last[d].delete();
         err_m[d] = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      in_valid_v[0] = 1'b1; in_data_v[0] = 13'h00AA; in_index_v[0] = 2'd0;
      step();
      in_valid_v[0] = 1'b0;
      drain();
      chk("post-reset beats", log_data[0].size(), 4);
      if (log_data[0].size() == 4) begin
         chk("post-reset data[0]", log_data[0][0], 13'h00AA);
         chk("post-reset hit[0]", log_hit[0][0], 1'b1);
         chk("post-reset last[3]", log_last[0][3], 1'b1);
      end

      // Randomized traffic on both instances
      for (int c = 0; c < 600; c++) begin
         for (int d = 0; d < 2; d++) begin
            in_valid_v[d]  = ($urandom_range(0, 2) != 0);
            in_data_v[d]   = DW'($urandom);
            in_index_v[d]  = 2'($urandom_range(0, 3));
            out_ready_v[d] = ($urandom_range(0, 3) != 0);
         end
         step();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
